// File: rtl/mem_bist_pkg.sv
// Shared definitions for the on-chip RAM fill/verify engine.
// Holds the default geometry of the 1024x32 RAM, the saturation ceiling
// of the mismatch counter, and the controller state encoding.
package mem_bist_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // Mismatch counter never exceeds this value (one per RAM word).
  localparam int ERR_SAT    = 1024;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    VERIFY,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mem_bist_if.sv
// RAM-side bus of the fill/verify engine (second port of the Nios II
// on-chip RAM).
//   master : engine side  - drives address/byteenable/chipselect/write/
//            writedata/clken, receives readdata.
//   slave  : RAM side     - the mirror image.
// readdata is valid the cycle after the address is presented.
interface mem_bist_if
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );

endinterface

// File: rtl/mem_bist_checker.sv
// Registered compare stage of the verify path.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_clear            clears the error fields (new command accepted)
//   i_vld              a read result is present on i_rdata this cycle
//   i_addr, i_exp      address and expected pattern of that read
//   i_rdata            RAM read data
//   o_err_count        mismatch count, saturating
//   o_first_err_addr   address of the first mismatch since the last clear
module mem_bist_checker
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W:0]   o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam logic [ADDR_W:0] SAT = (ADDR_W+1)'(ERR_SAT);

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v >= SAT) ? SAT : v + (ADDR_W+1)'(1);
  endfunction

  logic [ADDR_W:0]   r_err_count;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic              w_miss;

  assign w_miss = i_vld && (i_rdata != i_exp);

  // ---- stage p2: compare result registered into the error fields ----
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (w_miss) begin
      r_err_count <= sat_inc(r_err_count);
      if (r_err_count == '0) r_first_err_addr <= i_addr;
    end
  end

  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: rtl/onchip_mem_bist.sv
// Fill/verify engine for the 1024x32 on-chip RAM.
// On start it either writes seed+i to word (base_addr+i) for i=0..len-1,
// or reads the same window back and counts mismatches against that pattern.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, mode                 command strobe (IDLE only), 0=fill 1=verify
//   base_addr, len, seed        command operands, sampled with start
//   busy, done                  activity flag, one-cycle completion pulse
//   err_count, first_err_addr   verify results, held until the next start
//   ram                         RAM bus (master side)
module onchip_mem_bist
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  mem_bist_if.master        ram
);

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;     // index of the next word to present
  logic              r_busy;
  logic              r_done;
  logic              r_cs;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;    // doubles as the address generator
  logic [DATA_W-1:0] r_wdata;   // doubles as the pattern generator

  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_exp_p1;

  logic              w_clear;

  assign w_clear = (r_state == IDLE) && start;

  // ---- stage p0: command FSM, address and pattern generation ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_len   <= len;
            r_addr  <= base_addr;
            r_wdata <= seed;
            r_idx   <= (ADDR_W+1)'(1);
            if (len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= mode ? VERIFY : FILL;
              r_busy  <= 1'b1;
              r_cs    <= 1'b1;
              r_we    <= ~mode;
            end
          end
        end
        FILL, VERIFY: begin
          // r_idx == r_len means the word now on the bus is the last one.
          if (r_idx == r_len) begin
            r_cs <= 1'b0;
            r_we <= 1'b0;
            if (r_state == FILL) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_wdata <= r_wdata + DATA_W'(1);
            r_idx   <= r_idx + (ADDR_W+1)'(1);
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: align address/pattern with the RAM's 1-cycle read ----
  always_ff @(posedge clk) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= r_cs & ~r_we;
  end

  always_ff @(posedge clk) begin
    r_addr_p1 <= r_addr;
    r_exp_p1  <= r_wdata;
  end

  mem_bist_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .clk              (clk),
    .reset            (reset),
    .i_clear          (w_clear),
    .i_vld            (r_vld_p1),
    .i_addr           (r_addr_p1),
    .i_exp            (r_exp_p1),
    .i_rdata          (ram.readdata),
    .o_err_count      (err_count),
    .o_first_err_addr (first_err_addr)
  );

  assign busy           = r_busy;
  assign done           = r_done;
  assign ram.address    = r_addr;
  assign ram.byteenable = 4'hF;
  assign ram.chipselect = r_cs;
  assign ram.write      = r_we;
  assign ram.writedata  = r_wdata;
  assign ram.clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_bist.sv
// Scoreboard bench for onchip_mem_bist with a behavioural 1024x32 RAM.
`timescale 1ns/1ps
module tb_onchip_mem_bist;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] seed = '0;
  logic          busy;
  logic          done;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  onchip_mem_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .base_addr      (base_addr),
    .len            (len),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .ram            (ram_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model with backdoor ----------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic          bk_init = 1'b0;
  logic          bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_data = '0;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hA5A5_0000 | DW'(i);
  endfunction

  always @(posedge clk) begin
    if (bk_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (bk_we) begin
      mem[bk_addr] <= bk_data;
    end else if (ram_if.clken && ram_if.chipselect) begin
      if (ram_if.write)
        for (int b = 0; b < 4; b++)
          if (ram_if.byteenable[b])
            mem[ram_if.address][8*b +: 8] <= ram_if.writedata[8*b +: 8];
      ram_if.readdata <= mem[ram_if.address];
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name, input logic [63:0] act);
    n_chk++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct packed {
    logic [31:0]   c;
    logic [AW:0]   err;
    logic [AW-1:0] first;
  } dn_t;

  wr_t           wr_q [$];
  logic [AW-1:0] rd_q [$];
  dn_t           dn_q [$];
  int n_done = 0;
  int n_cs   = 0;
  int n_busy = 0;

  // Monitor: pops an expectation whenever the DUT presents an access or done.
  always @(negedge clk) begin
    wr_t           w;
    logic [AW-1:0] ra;
    dn_t           dn;
    if (busy === 1'b1) n_busy++;
    if (ram_if.chipselect === 1'b1) begin
      n_cs++;
      if (ram_if.write === 1'b1) begin
        if (wr_q.size() == 0) fail_evt("spurious_write", {22'd0, ram_if.address, ram_if.writedata});
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", 64'(ram_if.address), 64'(w.a));
          chk("wr_data", 64'(ram_if.writedata), 64'(w.d));
        end
      end else begin
        if (rd_q.size() == 0) fail_evt("spurious_read", 64'(ram_if.address));
        else begin
          ra = rd_q.pop_front();
          chk("rd_addr", 64'(ram_if.address), 64'(ra));
        end
      end
    end
    if (done === 1'b1) begin
      n_done++;
      if (dn_q.size() == 0) fail_evt("spurious_done", 64'(cyc));
      else begin
        dn = dn_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(dn.c));
        chk("done_err_count", 64'(err_count), 64'(dn.err));
        chk("done_first_err_addr", 64'(first_err_addr), 64'(dn.first));
        chk("done_busy_low", 64'(busy), 64'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Issues one command and pushes its expected accesses and completion.
  task automatic run_cmd(input logic m, input int b, input int l, input logic [DW-1:0] s,
                         input logic [AW:0] e_err, input logic [AW-1:0] e_first,
                         input int n_acc, input bit exp_done, output int t);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            dc;
    @(negedge clk);
    t = cyc;
    for (int i = 0; i < n_acc; i++) begin
      a = AW'(b + i);
      d = s + DW'(i);
      if (!m) begin
        wr_q.push_back({a, d});
        exp_mem[a] = d;
      end else begin
        rd_q.push_back(a);
      end
    end
    dc = (l == 0) ? t + 1 : (m ? t + l + 2 : t + l + 1);
    if (exp_done) dn_q.push_back({32'(dc), e_err, e_first});
    start     = 1'b1;
    mode      = m;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    seed      = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget, input string name);
    int k;
    k = 0;
    while (n_done == prev && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_done == prev) fail_evt({name, "_timeout"}, 64'(k));
    @(negedge clk);
  endtask

  task automatic check_mem(input int lo, input int cnt, input string name);
    logic [AW-1:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = AW'(lo + i);
      chk(name, 64'(mem[a]), 64'(exp_mem[a]));
    end
  endtask

  task automatic bk_write(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    bk_addr = AW'(a);
    bk_data = d;
    bk_we   = 1'b1;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int nd;
    int cs0;
    int b0;
    localparam logic [DW-1:0] S_D = 32'hC0DE_0000;

    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
    reset   = 1'b1;
    bk_init = 1'b1;
    @(negedge clk);
    bk_init = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_chipselect", 64'(ram_if.chipselect), 64'd0);
    chk("rst_write", 64'(ram_if.write), 64'd0);
    chk("rst_address", 64'(ram_if.address), 64'd0);
    chk("rst_writedata", 64'(ram_if.writedata), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_first_err_addr", 64'(first_err_addr), 64'd0);
    chk("rst_byteenable", 64'(ram_if.byteenable), 64'hF);
    chk("rst_clken", 64'(ram_if.clken), 64'd1);
    reset = 1'b0;

    // Fill with pattern wrap past 2^32; stray starts while busy and on done.
    nd = n_done;
    run_cmd(1'b0, 10, 4, 32'hFFFF_FFFE, '0, '0, 4, 1'b1, t);
    chk("fill_busy_t1", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; base_addr = 10'd500; len = 11'd3; seed = 32'h0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fill_busy_after_done", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    chk("fill_done_count", 64'(n_done - nd), 64'd1);
    check_mem(9, 6, "mem_fill_base10");

    // Fill across the top of the address space.
    nd = n_done;
    run_cmd(1'b0, 1022, 4, 32'h0, '0, '0, 4, 1'b1, t);
    wait_done(nd, 20, "fill_wrap");
    check_mem(1020, 8, "mem_fill_wrap");

    // Clean fill, corrupt two words, verify.
    nd = n_done;
    run_cmd(1'b0, 0, 16, S_D, '0, '0, 16, 1'b1, t);
    wait_done(nd, 40, "fill16");
    bk_write(5, ~(S_D + 32'd5));
    bk_write(9, (S_D + 32'd9) ^ 32'h0000_0100);
    nd = n_done;
    run_cmd(1'b1, 0, 16, S_D, 11'd2, 10'd5, 16, 1'b1, t);
    wait_done(nd, 40, "verify16");
    repeat (2) @(negedge clk);
    chk("err_count_held", 64'(err_count), 64'd2);
    chk("first_err_held", 64'(first_err_addr), 64'd5);

    // len==0: immediate done, no access, error fields cleared.
    cs0 = n_cs;
    b0  = n_busy;
    nd  = n_done;
    run_cmd(1'b1, 0, 0, 32'h0, '0, '0, 0, 1'b1, t);
    wait_done(nd, 10, "len0");
    chk("len0_no_access", 64'(n_cs - cs0), 64'd0);
    chk("len0_no_busy", 64'(n_busy - b0), 64'd0);

    // Reset while filling: word 39 is on the bus at the reset edge.
    run_cmd(1'b0, 0, 100, 32'h0000_1000, '0, '0, 40, 1'b0, t);
    while (cyc < t + 40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_chipselect", 64'(ram_if.chipselect), 64'd0);
    chk("midrst_write", 64'(ram_if.write), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_mem(0, 100, "mem_partial_fill");

    // Whole-RAM fill then verify.
    nd = n_done;
    run_cmd(1'b0, 0, 1024, 32'h1234_5678, '0, '0, 1024, 1'b1, t);
    wait_done(nd, 1100, "fill1024");
    nd = n_done;
    run_cmd(1'b1, 0, 1024, 32'h1234_5678, '0, '0, 1024, 1'b1, t);
    wait_done(nd, 1100, "verify1024");

    repeat (4) @(negedge clk);
    chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    chk("done_queue_empty", 64'(dn_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
